align_buffer: RTL and testbench
===============================

# align_buffer

Instruction aligner and fetch/decode pipeline register for the RV32IMC core. It accepts 32-bit fetch words that may start on a halfword boundary and carves them into whole 16-bit or 32-bit instructions, including 32-bit instructions that straddle two fetch words. It presents one registered instruction per cycle to the decode stage, where the opcode, register and immediate fields are extracted.

## Interface
- XLEN, 32: datapath and PC width.
- clk_i  input  1  core clock; all state updates on rising edge.
- rst_i  input  1  reset, asynchronous, active-high.
- flush_i  input  1  pipeline flush (branch, jump or trap redirect); synchronous.
- fetch_valid_i  input  1  fetch word valid.
- fetch_data_i  input  32  fetch word; [15:0] is the lower halfword, [31:16] the upper halfword.
- fetch_pc_i  input  XLEN  address of the first valid halfword; bit 1 set means only [31:16] is valid; bit 0 is always 0.
- fetch_ready_o  output  1  fetch word consumed this cycle (valid & ready = handshake).
- decode_ready_i  input  1  decode accepts the output this cycle.
- inst_valid_o  output  1  output instruction valid.
- inst_o  output  32  instruction; compressed instructions are zero-extended in [31:16].
- inst_pc_o  output  XLEN  instruction address.
- is_comp_o  output  1  instruction is 16-bit (inst_o[1:0] != 2'b11).

## Operation
- State:
  - Residual halfword register: hw_q[15:0], hw_pc_q, hw_valid_q.
  - Output register: inst_valid_o, inst_o, inst_pc_o, is_comp_o.
- advance = !inst_valid_o | decode_ready_i. The output register loads only when advance=1.
- A halfword h is compressed iff h[1:0] != 2'b11.
- Case R: hw_valid_q=1 and hw_q is compressed.
  - Emit {16'h0, hw_q} at hw_pc_q, is_comp=1.
  - Clear the residual. fetch_ready_o=0, so the fetch word is held and used next cycle.
  - This case does not depend on fetch_valid_i.
- Case S: hw_valid_q=1, hw_q is 32-bit, fetch_valid_i=1.
  - Emit {fetch_data_i[15:0], hw_q} at hw_pc_q, is_comp=0.
  - Upper halfword becomes the residual: hw_q=fetch_data_i[31:16], hw_pc_q=hw_pc_q+4.
  - fetch_ready_o=1.
- Case L: hw_valid_q=0, fetch_pc_i[1]=0, fetch_valid_i=1.
  - Lower halfword compressed:
    - Emit {16'h0, fetch_data_i[15:0]} at fetch_pc_i, is_comp=1.
    - Residual becomes fetch_data_i[31:16] at fetch_pc_i+2.
  - Lower halfword 32-bit:
    - Emit fetch_data_i at fetch_pc_i, is_comp=0.
    - Residual stays empty.
  - fetch_ready_o=1.
- Case U: hw_valid_q=0, fetch_pc_i[1]=1, fetch_valid_i=1.
  - Upper halfword compressed:
    - Emit {16'h0, fetch_data_i[31:16]} at fetch_pc_i, is_comp=1.
    - Residual stays empty.
  - Upper halfword 32-bit:
    - Store it as the residual at fetch_pc_i. Emit nothing (inst_valid_o loads 0).
  - fetch_ready_o=1.
- hw_valid_q=1, hw_q 32-bit, fetch_valid_i=0: emit nothing; the residual is held.
- If advance=0, no case executes. fetch_ready_o=0, and the residual and output register hold.
- PC arithmetic is modulo 2^XLEN; wrap from 0xFFFF_FFFE is not flagged.
- The block does not check instruction legality; illegal encodings pass through.

## Timing
- Reset values:
  - inst_valid_o=0, inst_o=32'h0000_0013 (NOP), inst_pc_o=0, is_comp_o=0.
  - hw_valid_q=0, hw_q=0, hw_pc_q=0.
- Latency: an instruction whose last halfword is handshaked in cycle N appears on the outputs in cycle N+1.
- fetch_ready_o is combinational from state, fetch_pc_i[1], flush_i and decode_ready_i. It must not depend on fetch_data_i content when a case consumes unconditionally.
- Throughput:
  - One instruction per cycle in steady state.
  - Case U with a 32-bit upper half costs one bubble.
  - Case R consumes no fetch word.
- Stall: with inst_valid_o=1 and decode_ready_i=0, all outputs stay stable cycle to cycle.
- Flush, at the next edge:
  - Clears inst_valid_o and hw_valid_q.
  - Forces fetch_ready_o=0 in the flush cycle; the fetch word is discarded and not consumed.
  - Takes priority over every case and over a stall.
- The first fetch after a flush may have fetch_pc_i[1]=1 (Case U).
- Reset asserted mid-operation clears all state immediately, including a pending residual and a held output.

## Test plan
- Aligned 32-bit stream: words 0x00500093 at 0x0, 0x00A00113 at 0x4 -> outputs at 0x0 then 0x4, is_comp=0, one per cycle, fetch_ready_o=1 each cycle.
- Compressed pair: word 0x45854505 at 0x100 -> cycle 1 inst 0x00004505 @0x100 is_comp=1; cycle 2 inst 0x00004585 @0x102 from residual, fetch_ready_o=0 during Case R.
- Straddle: word 0x00934505 at 0x200, then 0x00000050 at 0x204 -> 0x00004505 @0x200, then 0x00500093 @0x202 is_comp=0; residual becomes 0x0000 @0x206.
- Halfword-target redirect: flush_i, then fetch_pc_i=0x302 with data 0x00930000, next word 0x00000050 -> one bubble, then 0x00500093 @0x302.
- Backpressure: decode_ready_i=0 for 3 cycles during the compressed pair -> outputs frozen, fetch_ready_o=0, no instruction lost or duplicated after release.
- Flush with residual pending and reset mid-stall -> inst_valid_o=0 next cycle, hw_valid_q=0, inst_o returns 0x00000013 after reset.

Source files
------------

// File: rtl/align_buffer.sv
// Instruction aligner and fetch/decode pipeline register: carves 32-bit fetch
// words into whole 16/32-bit instructions and presents one per cycle to decode.
module align_buffer #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            flush_i,
    input  logic            fetch_valid_i,
    input  logic [31:0]     fetch_data_i,
    input  logic [XLEN-1:0] fetch_pc_i,
    output logic            fetch_ready_o,
    input  logic            decode_ready_i,
    output logic            inst_valid_o,
    output logic [31:0]     inst_o,
    output logic [XLEN-1:0] inst_pc_o,
    output logic            is_comp_o
);

    localparam int unsigned HW_W   = 16;
    localparam int unsigned INST_W = 32;
    localparam logic [INST_W-1:0] NOP = 32'h0000_0013;

    logic [HW_W-1:0]   hw_q, hw_d;
    logic [XLEN-1:0]   hw_pc_q, hw_pc_d;
    logic              hw_valid_q, hw_valid_d;

    logic              inst_valid_d;
    logic [INST_W-1:0] inst_d;
    logic [XLEN-1:0]   inst_pc_d;
    logic              is_comp_d;

    logic              advance;
    logic              hw_comp;
    logic              lo_comp;
    logic              up_comp;

    assign advance = !inst_valid_o || decode_ready_i;
    assign hw_comp = hw_q[1:0] != 2'b11;
    assign lo_comp = fetch_data_i[1:0] != 2'b11;
    assign up_comp = fetch_data_i[17:16] != 2'b11;

    // Next-state selection; flush outranks both stall and every alignment case.
    always_comb begin
        hw_d          = hw_q;
        hw_pc_d       = hw_pc_q;
        hw_valid_d    = hw_valid_q;
        inst_valid_d  = inst_valid_o;
        inst_d        = inst_o;
        inst_pc_d     = inst_pc_o;
        is_comp_d     = is_comp_o;
        fetch_ready_o = 1'b0;

        if (flush_i) begin
            inst_valid_d = 1'b0;
            hw_valid_d   = 1'b0;
        end else if (advance) begin
            // A compressed residual is drained without touching the fetch word.
            fetch_ready_o = !(hw_valid_q && hw_comp);
            inst_valid_d  = 1'b0;
            if (hw_valid_q) begin
                if (hw_comp) begin
                    inst_valid_d = 1'b1;
                    inst_d       = {16'h0000, hw_q};
                    inst_pc_d    = hw_pc_q;
                    is_comp_d    = 1'b1;
                    hw_valid_d   = 1'b0;
                end else if (fetch_valid_i) begin
                    inst_valid_d = 1'b1;
                    inst_d       = {fetch_data_i[15:0], hw_q};
                    inst_pc_d    = hw_pc_q;
                    is_comp_d    = 1'b0;
                    hw_d         = fetch_data_i[31:16];
                    hw_pc_d      = hw_pc_q + XLEN'(4);
                end
            end else if (fetch_valid_i) begin
                if (!fetch_pc_i[1]) begin
                    inst_valid_d = 1'b1;
                    inst_pc_d    = fetch_pc_i;
                    if (lo_comp) begin
                        inst_d     = {16'h0000, fetch_data_i[15:0]};
                        is_comp_d  = 1'b1;
                        hw_d       = fetch_data_i[31:16];
                        hw_pc_d    = fetch_pc_i + XLEN'(2);
                        hw_valid_d = 1'b1;
                    end else begin
                        inst_d     = fetch_data_i;
                        is_comp_d  = 1'b0;
                    end
                end else if (up_comp) begin
                    inst_valid_d = 1'b1;
                    inst_d       = {16'h0000, fetch_data_i[31:16]};
                    inst_pc_d    = fetch_pc_i;
                    is_comp_d    = 1'b1;
                end else begin
                    hw_d       = fetch_data_i[31:16];
                    hw_pc_d    = fetch_pc_i;
                    hw_valid_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            hw_q         <= '0;
            hw_pc_q      <= '0;
            hw_valid_q   <= 1'b0;
            inst_valid_o <= 1'b0;
            inst_o       <= NOP;
            inst_pc_o    <= '0;
            is_comp_o    <= 1'b0;
        end else begin
            hw_q         <= hw_d;
            hw_pc_q      <= hw_pc_d;
            hw_valid_q   <= hw_valid_d;
            inst_valid_o <= inst_valid_d;
            inst_o       <= inst_d;
            inst_pc_o    <= inst_pc_d;
            is_comp_o    <= is_comp_d;
        end
    end

endmodule

// File: tb/tb_align_buffer.sv
// Bench for align_buffer: directed scenarios, then random programs checked
// against an in-order instruction list derived from the halfword image.
module tb_align_buffer;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned MEMHW = 64;
    localparam logic [31:0] BASE  = 32'h0000_1000;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        comp;
    } exp_t;

    logic            clk;
    logic            rst_i;
    logic            flush_i;
    logic            fetch_valid_i;
    logic [31:0]     fetch_data_i;
    logic [XLEN-1:0] fetch_pc_i;
    logic            fetch_ready_o;
    logic            decode_ready_i;
    logic            inst_valid_o;
    logic [31:0]     inst_o;
    logic [XLEN-1:0] inst_pc_o;
    logic            is_comp_o;

    int n_assert;
    int n_fail;

    logic [15:0] mem [MEMHW];
    exp_t        exp_q [$];

    align_buffer #(.XLEN(XLEN)) dut (
        .clk_i          (clk),
        .rst_i          (rst_i),
        .flush_i        (flush_i),
        .fetch_valid_i  (fetch_valid_i),
        .fetch_data_i   (fetch_data_i),
        .fetch_pc_i     (fetch_pc_i),
        .fetch_ready_o  (fetch_ready_o),
        .decode_ready_i (decode_ready_i),
        .inst_valid_o   (inst_valid_o),
        .inst_o         (inst_o),
        .inst_pc_o      (inst_pc_o),
        .is_comp_o      (is_comp_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Inputs change just after the falling edge, well away from the rising edge.
    task automatic drive(input logic fv, input logic [31:0] fd, input logic [31:0] fp,
                         input logic dr, input logic fl);
        @(negedge clk);
        fetch_valid_i  = fv;
        fetch_data_i   = fd;
        fetch_pc_i     = fp;
        decode_ready_i = dr;
        flush_i        = fl;
        #1;
    endtask

    task automatic check_out(input string tag, input logic v, input logic [31:0] i,
                             input logic [31:0] p, input logic c);
        check({tag, "_valid"}, 32'(inst_valid_o), 32'(v));
        if (v) begin
            check({tag, "_inst"}, inst_o, i);
            check({tag, "_pc"}, inst_pc_o, p);
            check({tag, "_comp"}, 32'(is_comp_o), 32'(c));
        end
    endtask

    // Random halfword image, about half of them 32-bit instruction starts.
    task automatic fill_mem();
        logic [15:0] h;
        for (int i = 0; i < int'(MEMHW); i++) begin
            h = 16'($urandom);
            if ($urandom_range(0, 1) == 1) h[1:0] = 2'b11;
            else h[0] = 1'b0;
            mem[i] = h;
        end
    endtask

    // Reference: walk the image from start, one whole instruction at a time.
    task automatic build_expected(input logic [31:0] start);
        int   i;
        exp_t e;
        exp_q.delete();
        i = int'((start - BASE) >> 1);
        while (i < int'(MEMHW)) begin
            if (mem[i][1:0] != 2'b11) begin
                e.inst = {16'h0000, mem[i]};
                e.pc   = BASE + 32'(2 * i);
                e.comp = 1'b1;
                exp_q.push_back(e);
                i += 1;
            end else if (i + 1 < int'(MEMHW)) begin
                e.inst = {mem[i + 1], mem[i]};
                e.pc   = BASE + 32'(2 * i);
                e.comp = 1'b0;
                exp_q.push_back(e);
                i += 2;
            end else begin
                i += 2;
            end
        end
    endtask

    task automatic random_run(input logic [31:0] start);
        logic [31:0] fa;
        int          w;
        int          cyc;
        logic        fv;
        logic        stall_prev;
        exp_t        snap;
        exp_t        e;
        fill_mem();
        build_expected(start);
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b1);
        fa = start;
        cyc = 0;
        stall_prev = 1'b0;
        snap = '0;
        while (exp_q.size() > 0 && cyc < 3000) begin
            w  = int'((fa - BASE) >> 2);
            fv = (2 * w + 1 < int'(MEMHW)) && ($urandom_range(0, 3) != 0);
            drive(fv, fv ? {mem[2 * w + 1], mem[2 * w]} : $urandom, fa,
                  $urandom_range(0, 3) != 0, 1'b0);
            if (stall_prev) begin
                check("stall_valid", 32'(inst_valid_o), 32'h1);
                check("stall_inst", inst_o, snap.inst);
                check("stall_pc", inst_pc_o, snap.pc);
                check("stall_comp", 32'(is_comp_o), 32'(snap.comp));
            end
            if (inst_valid_o && decode_ready_i) begin
                e = exp_q.pop_front();
                check("rand_inst", inst_o, e.inst);
                check("rand_pc", inst_pc_o, e.pc);
                check("rand_comp", 32'(is_comp_o), 32'(e.comp));
            end
            if (fetch_valid_i && fetch_ready_o) fa = (fa & ~32'h3) + 32'h4;
            stall_prev = inst_valid_o && !decode_ready_i;
            snap.inst  = inst_o;
            snap.pc    = inst_pc_o;
            snap.comp  = is_comp_o;
            cyc++;
        end
        check("rand_remaining", 32'(exp_q.size()), 32'h0);
    endtask

    initial begin
        n_assert       = 0;
        n_fail         = 0;
        rst_i          = 1'b1;
        flush_i        = 1'b0;
        fetch_valid_i  = 1'b0;
        fetch_data_i   = '0;
        fetch_pc_i     = '0;
        decode_ready_i = 1'b1;

        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        check("rst_valid", 32'(inst_valid_o), 32'h0);
        check("rst_inst", inst_o, 32'h0000_0013);
        check("rst_pc", inst_pc_o, 32'h0);
        check("rst_comp", 32'(is_comp_o), 32'h0);
        rst_i = 1'b0;

        // Aligned 32-bit stream
        drive(1'b1, 32'h0050_0093, 32'h0, 1'b1, 1'b0);
        check("al0_rdy", 32'(fetch_ready_o), 32'h1);
        drive(1'b1, 32'h00A0_0113, 32'h4, 1'b1, 1'b0);
        check_out("al0", 1'b1, 32'h0050_0093, 32'h0, 1'b0);
        check("al1_rdy", 32'(fetch_ready_o), 32'h1);

        // Compressed pair with three cycles of backpressure
        drive(1'b1, 32'h4585_4505, 32'h100, 1'b1, 1'b0);
        check_out("al1", 1'b1, 32'h00A0_0113, 32'h4, 1'b0);
        check("cp_rdy", 32'(fetch_ready_o), 32'h1);
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
            check_out("cp_bp", 1'b1, 32'h0000_4505, 32'h100, 1'b1);
            check("cp_bp_rdy", 32'(fetch_ready_o), 32'h0);
        end
        drive(1'b1, 32'h0093_4505, 32'h200, 1'b1, 1'b0);
        check_out("cp_hold", 1'b1, 32'h0000_4505, 32'h100, 1'b1);
        check("cp_r_rdy", 32'(fetch_ready_o), 32'h0);

        // Straddle, then a flush with a compressed residual pending
        drive(1'b1, 32'h0093_4505, 32'h200, 1'b1, 1'b0);
        check_out("cp1", 1'b1, 32'h0000_4585, 32'h102, 1'b1);
        check("st0_rdy", 32'(fetch_ready_o), 32'h1);
        drive(1'b1, 32'h0000_0050, 32'h204, 1'b1, 1'b0);
        check_out("st0", 1'b1, 32'h0000_4505, 32'h200, 1'b1);
        check("st1_rdy", 32'(fetch_ready_o), 32'h1);
        drive(1'b1, 32'h0093_0000, 32'h302, 1'b1, 1'b1);
        check_out("st1", 1'b1, 32'h0050_0093, 32'h202, 1'b0);
        check("fl_rdy", 32'(fetch_ready_o), 32'h0);

        // Halfword-target redirect costs one bubble
        drive(1'b1, 32'h0093_0000, 32'h302, 1'b1, 1'b0);
        check_out("fl", 1'b0, 32'h0, 32'h0, 1'b0);
        check("u_rdy", 32'(fetch_ready_o), 32'h1);
        drive(1'b1, 32'h0000_0050, 32'h304, 1'b1, 1'b0);
        check_out("u_bubble", 1'b0, 32'h0, 32'h0, 1'b0);
        check("u_s_rdy", 32'(fetch_ready_o), 32'h1);
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        check_out("u_inst", 1'b1, 32'h0050_0093, 32'h302, 1'b0);
        check("u_stall_rdy", 32'(fetch_ready_o), 32'h0);

        // Reset mid-stall with a residual pending clears everything at once
        #2;
        rst_i = 1'b1;
        #1;
        check("mrst_valid", 32'(inst_valid_o), 32'h0);
        check("mrst_inst", inst_o, 32'h0000_0013);
        check("mrst_pc", inst_pc_o, 32'h0);
        check("mrst_comp", 32'(is_comp_o), 32'h0);
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        rst_i = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        check("mrst_rdy", 32'(fetch_ready_o), 32'h1);
        check_out("mrst_idle", 1'b0, 32'h0, 32'h0, 1'b0);

        random_run(BASE);
        random_run(BASE + 32'h2);
        random_run(BASE);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
